uart_tx_arbiter: RTL and testbench

- Shares the single UART0 transmit byte path between NREQ byte-stream requesters, e.g. CPU stdout, debug-tester status and a trace source.
- Grants are round-robin and held for a whole "line": until an end-of-line byte is sent, a burst limit is reached, or the owner goes idle for too long.
- Sits between the requesters and the UART TX serializer, which feeds the capture device in simulation.
- Output byte is registered, giving one-deep buffering toward the serializer.

---
 rtl/uart_tx_arbiter.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, line-locked arbiter sharing one UART TX byte path.
// Ports:
//   CLK, RST           clock, async active-high reset
//   req_valid/req_data per-requester byte stream (byte i at [8i+7:8i])
//   req_ready          per-requester accept (only the owner can be ready)
//   tx_valid/tx_data   registered byte toward the serializer
//   tx_ready           serializer accept
//   grant              one-hot current owner, zero when idle
//   busy               high while a grant is locked
module uart_tx_arbiter #(
  parameter int         NREQ         = 4,
  parameter int         MAX_BURST    = 64,
  parameter int         IDLE_TIMEOUT = 16,
  parameter logic [7:0] EOL_CHAR     = 8'h0A
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [NREQ-1:0]   grant,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    S_IDLE,
    S_LOCK
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_last;
  logic [7:0]      r_burst_cnt;
  logic [7:0]      r_idle_cnt;
  logic            r_tx_valid;
  logic [7:0]      r_tx_data;
  logic [NREQ-1:0] r_grant;
  logic            r_busy;

  logic            w_any;
  logic [IW-1:0]   w_sel;
  logic [IW:0]     w_pick;
  logic [NREQ-1:0] w_sel_oh;
  logic            w_own_valid;
  logic            w_own_ready;
  logic [7:0]      w_own_data;
  logic            w_accept;
  logic            w_eol;
  logic            w_burst_end;
  logic            w_timeout;
  logic            w_release;

  // First valid index after the previous owner, wrapping.
  // MSB of the result flags that something was found.
  function automatic logic [IW:0] rr_pick(
    input logic [NREQ-1:0] v,
    input logic [IW-1:0]   last
  );
    logic [IW:0]   r;
    logic [IW-1:0] idx;
    r = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (!r[IW] && v[idx]) begin
        r = {1'b1, idx};
      end
    end
    return r;
  endfunction

  assign w_pick   = rr_pick(req_valid, r_last);
  assign w_any    = w_pick[IW];
  assign w_sel    = w_pick[IW-1:0];
  assign w_sel_oh = {{(NREQ-1){1'b0}}, 1'b1} << w_sel;

  always_comb begin
    w_own_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant[i]) begin
        w_own_data = req_data[8*i +: 8];
      end
    end
  end

  // The output register can take a new byte when empty
  // or when it is draining this cycle.
  assign w_own_valid = |(req_valid & r_grant);
  assign w_own_ready = (r_state == S_LOCK)
                     & (~r_tx_valid | tx_ready);
  assign w_accept    = w_own_valid & w_own_ready;

  assign w_eol       = (w_own_data == EOL_CHAR);
  assign w_burst_end = (r_burst_cnt == 8'(MAX_BURST - 1));

  // Only an absent byte counts as idle; a stalled owner
  // (valid but not ready) never times out.
  assign w_timeout = (r_state == S_LOCK) & ~w_own_valid
                   & (r_idle_cnt == 8'(IDLE_TIMEOUT - 1));

  assign w_release = (w_accept & (w_eol | w_burst_end))
                   | w_timeout;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_owner     <= '0;
      r_last      <= IW'(NREQ - 1);
      r_burst_cnt <= '0;
      r_idle_cnt  <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= 8'h00;
      r_grant     <= '0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          // Pending byte keeps draining between grants.
          if (tx_ready) begin
            r_tx_valid <= 1'b0;
          end
          if (w_any) begin
            r_state     <= S_LOCK;
            r_owner     <= w_sel;
            r_grant     <= w_sel_oh;
            r_busy      <= 1'b1;
            r_burst_cnt <= '0;
            r_idle_cnt  <= '0;
          end
        end
        S_LOCK: begin
          if (w_accept) begin
            r_tx_data  <= w_own_data;
            r_tx_valid <= 1'b1;
            r_idle_cnt <= '0;
            if (r_burst_cnt < 8'(MAX_BURST)) begin
              r_burst_cnt <= r_burst_cnt + 8'd1;
            end
          end else begin
            if (tx_ready) begin
              r_tx_valid <= 1'b0;
            end
            if (!w_own_valid &&
                r_idle_cnt < 8'(IDLE_TIMEOUT - 1)) begin
              r_idle_cnt <= r_idle_cnt + 8'd1;
            end
          end
          if (w_release) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_last  <= r_owner;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_grant & {NREQ{w_own_ready}};
  assign tx_valid  = r_tx_valid;
  assign tx_data   = r_tx_data;
  assign grant     = r_grant;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter.
// Sources feed byte queues; monitor checks bytes and grant order.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;

  logic              CLK;
  logic              RST;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic [NREQ-1:0]   grant;
  logic              busy;

  uart_tx_arbiter #(
    .NREQ(NREQ),
    .MAX_BURST(64),
    .IDLE_TIMEOUT(16),
    .EOL_CHAR(8'h0A)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .grant(grant),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit seen;
  int acc;
  int rel;

  logic [7:0]      src_q [NREQ][$];
  logic [7:0]      exp_q [$];
  logic [NREQ-1:0] exp_g_q [$];
  int              gcyc_q [$];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input int r, input string s);
    for (int i = 0; i < s.len(); i++) src_q[r].push_back(s[i]);
  endtask

  task automatic expect_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    exp_q.delete();
    exp_g_q.delete();
    gcyc_q.delete();
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #2;
    RST = 1'b1;
    clear_all();
    @(posedge CLK);
    @(posedge CLK);
    #2;
    RST = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit done;
    bit empty;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge CLK);
      empty = 1'b1;
      for (int i = 0; i < NREQ; i++)
        if (src_q[i].size() != 0) empty = 1'b0;
      done = empty && exp_q.size() == 0
          && grant == '0 && !tx_valid;
    end
    chk({name, " drained"}, 32'(done), 32'd1);
  endtask

  // Source driver: inputs change 1 time unit after posedge,
  // handshakes are sampled at the preceding negedge.
  initial begin
    logic [NREQ-1:0] fire;
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge CLK);
      fire = req_valid & req_ready;
      @(posedge CLK);
      #1;
      for (int i = 0; i < NREQ; i++)
        if (!RST && fire[i] && src_q[i].size() != 0)
          void'(src_q[i].pop_front());
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = (src_q[i].size() != 0);
        req_data[8*i +: 8] =
          (src_q[i].size() != 0) ? src_q[i][0] : 8'h00;
      end
    end
  end

  // Monitor: bytes and new grants against the scoreboard.
  initial begin
    logic [NREQ-1:0] prev_g;
    prev_g = '0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected tx byte: got %0h, expected none",
                     tx_data);
          end else begin
            chk("tx byte", 32'(tx_data), 32'(exp_q.pop_front()));
          end
        end
        if (prev_g == '0 && grant != '0) begin
          gcyc_q.push_back(cyc);
          if (exp_g_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected grant: got %0b, expected none",
                     grant);
          end else begin
            chk("grant owner", 32'(grant), 32'(exp_g_q.pop_front()));
          end
        end
      end
      prev_g = RST ? '0 : grant;
    end
  end

  initial begin
    RST = 1'b1;
    tx_ready = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset tx_valid", 32'(tx_valid), 32'd0);
    chk("reset tx_data", 32'(tx_data), 32'd0);
    chk("reset grant", 32'(grant), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    @(posedge CLK);
    #2;
    RST = 1'b0;

    // 1: single line from requester 0
    tx_ready = 1'b1;
    do_reset();
    send(0, "AB\n");
    expect_str("AB\n");
    exp_g_q.push_back(4'b0001);
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge CLK);
      seen = req_valid[0];
    end
    chk("t1 valid seen", 32'(seen), 32'd1);
    chk("t1 grant before latency", 32'(grant), 32'd0);
    @(negedge CLK);
    chk("t1 grant latency", 32'(grant), 32'b0001);
    chk("t1 busy", 32'(busy), 32'd1);
    @(negedge CLK);
    chk("t1 byte0 valid", 32'(tx_valid), 32'd1);
    chk("t1 byte0", 32'(tx_data), 32'h41);
    @(negedge CLK);
    chk("t1 byte1", 32'(tx_data), 32'h42);
    @(negedge CLK);
    chk("t1 byte2", 32'(tx_data), 32'h0A);
    chk("t1 eol release", 32'(grant), 32'd0);
    wait_idle(20, "t1");

    // 2: all requesters, one line each, round robin
    do_reset();
    send(0, "a\nA\n");
    send(1, "b\n");
    send(2, "c\n");
    send(3, "d\n");
    expect_str("a\nb\nc\nd\nA\n");
    exp_g_q.push_back(4'b0001);
    exp_g_q.push_back(4'b0010);
    exp_g_q.push_back(4'b0100);
    exp_g_q.push_back(4'b1000);
    exp_g_q.push_back(4'b0001);
    wait_idle(60, "t2");
    chk("t2 grant count", 32'(gcyc_q.size()), 32'd5);
    if (gcyc_q.size() == 5)
      for (int i = 1; i < 5; i++)
        chk("t2 grant spacing", 32'(gcyc_q[i] - gcyc_q[i-1]), 32'd3);

    // 3: burst limit on a 70-byte stream
    do_reset();
    for (int i = 0; i < 70; i++) src_q[2].push_back(8'h55);
    send(3, "Z\n");
    for (int i = 0; i < 64; i++) exp_q.push_back(8'h55);
    expect_str("Z\n");
    for (int i = 0; i < 6; i++) exp_q.push_back(8'h55);
    exp_g_q.push_back(4'b0100);
    exp_g_q.push_back(4'b1000);
    exp_g_q.push_back(4'b0100);
    wait_idle(200, "t3");
    chk("t3 grant count", 32'(gcyc_q.size()), 32'd3);
    if (gcyc_q.size() >= 2)
      chk("t3 burst length", 32'(gcyc_q[1] - gcyc_q[0]), 32'd65);

    // 4: idle timeout after a single byte
    do_reset();
    send(0, "a\n");
    expect_str("a\n");
    exp_g_q.push_back(4'b0001);
    wait_idle(20, "t4 warmup");
    send(1, "K");
    expect_str("K");
    exp_g_q.push_back(4'b0010);
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge CLK);
      seen = req_valid[1] & req_ready[1];
    end
    acc = cyc + 1;
    chk("t4 owner accept", 32'(seen), 32'd1);
    @(posedge CLK);
    #2;
    send(0, "b\n");
    expect_str("b\n");
    exp_g_q.push_back(4'b0001);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge CLK);
      seen = (grant != 4'b0010);
    end
    rel = cyc;
    chk("t4 released", 32'(seen), 32'd1);
    chk("t4 timeout cycles", 32'(rel - acc), 32'd16);
    chk("t4 grant idle", 32'(grant), 32'd0);
    chk("t4 busy idle", 32'(busy), 32'd0);
    @(negedge CLK);
    chk("t4 waiting req0 granted", 32'(grant), 32'b0001);
    wait_idle(20, "t4");

    // 5: serializer backpressure for 20 cycles
    tx_ready = 1'b0;
    do_reset();
    send(1, "PQRS\n");
    expect_str("PQRS\n");
    exp_g_q.push_back(4'b0010);
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge CLK);
      seen = (grant == 4'b0010) && tx_valid;
    end
    chk("t5 first byte loaded", 32'(seen), 32'd1);
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge CLK);
      chk("t5 stall tx_valid", 32'(tx_valid), 32'd1);
      chk("t5 stall tx_data", 32'(tx_data), 32'h50);
      chk("t5 stall req_ready", 32'(req_ready), 32'd0);
      chk("t5 stall grant", 32'(grant), 32'b0010);
    end
    @(posedge CLK);
    #2;
    tx_ready = 1'b1;
    wait_idle(20, "t5");

    // 6: asynchronous reset mid-burst
    do_reset();
    send(2, "0123456789");
    expect_str("0123456789");
    exp_g_q.push_back(4'b0100);
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge CLK);
      seen = (grant == 4'b0100) && tx_valid;
    end
    chk("t6 mid-burst reached", 32'(seen), 32'd1);
    #2;
    RST = 1'b1;
    clear_all();
    #1;
    chk("t6 async req_ready", 32'(req_ready), 32'd0);
    chk("t6 async tx_valid", 32'(tx_valid), 32'd0);
    chk("t6 async tx_data", 32'(tx_data), 32'd0);
    chk("t6 async grant", 32'(grant), 32'd0);
    chk("t6 async busy", 32'(busy), 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #2;
    RST = 1'b0;
    send(0, "m\n");
    send(2, "n\n");
    expect_str("m\nn\n");
    exp_g_q.push_back(4'b0001);
    exp_g_q.push_back(4'b0100);
    wait_idle(30, "t6");

    chk("leftover bytes", 32'(exp_q.size()), 32'd0);
    chk("leftover grants", 32'(exp_g_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
